// File: rtl/i2s_tx_pkg.sv
// Shared types and constants for the DSP-mode I2S transmit channel.
package i2s_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFSET = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } tx_state_e;

    localparam logic [4:0] NB_8  = 5'd7;
    localparam logic [4:0] NB_16 = 5'd15;
    localparam logic [4:0] NB_24 = 5'd23;
    localparam logic [4:0] NB_32 = 5'd31;

    function automatic logic is_legal_len(input logic [4:0] num_bits);
        return (num_bits == NB_8) || (num_bits == NB_16) ||
               (num_bits == NB_24) || (num_bits == NB_32);
    endfunction

    // Keeps only the low num_bits+1 bits of a FIFO word.
    function automatic logic [31:0] word_mask(input logic [4:0] num_bits);
        return 32'hFFFF_FFFF >> (NB_32 - num_bits);
    endfunction

endpackage

// File: rtl/i2s_tx_serializer.sv
// One transmit lane: holding slot, shift register and registered serial bit.
module i2s_tx_serializer
    import i2s_tx_pkg::*;
(
    input  logic        sck_i,
    input  logic        rstn_i,
    input  logic        flush,
    input  logic        fill,
    input  logic [31:0] fill_data,
    input  logic        load,
    input  logic        shift,
    input  logic        stop,
    input  logic [4:0]  cfg_num_bits_i,
    input  logic        cfg_lsb_first_i,
    output logic        slot_full,
    output logic        underrun,
    output logic        sd
);

    logic [31:0] slot_q;
    logic [31:0] shreg_q;
    logic [31:0] word;
    logic [31:0] src;
    logic        full_q;
    logic        sd_q;

    // An empty slot at word start sends an all-zero word.
    assign word     = full_q ? (slot_q & word_mask(cfg_num_bits_i)) : '0;
    assign src      = load ? word : shreg_q;
    assign underrun = load & ~full_q;
    assign slot_full = full_q;
    assign sd        = sd_q;

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            full_q <= 1'b0;
            slot_q <= '0;
        end else if (flush) begin
            full_q <= 1'b0;
            slot_q <= '0;
        end else begin
            if (load)
                full_q <= 1'b0;
            if (fill) begin
                full_q <= 1'b1;
                slot_q <= fill_data;
            end
        end
    end

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shreg_q <= '0;
            sd_q    <= 1'b0;
        end else if (flush) begin
            shreg_q <= '0;
            sd_q    <= 1'b0;
        end else if (load || shift) begin
            sd_q    <= cfg_lsb_first_i ? src[0] : src[cfg_num_bits_i];
            shreg_q <= cfg_lsb_first_i ? (src >> 1) : (src << 1);
        end else if (stop) begin
            sd_q <= 1'b0;
        end
    end

endmodule

// File: rtl/i2s_tx_dsp_channel.sv
// DSP-mode I2S transmit channel: frame-sync FSM, bit/word/offset counters and FIFO steering.
module i2s_tx_dsp_channel
    import i2s_tx_pkg::*;
(
    input  logic        sck_i,
    input  logic        rstn_i,
    input  logic        i2s_ws_i,
    output logic        i2s_ch0_o,
    output logic        i2s_ch1_o,
    input  logic [31:0] fifo_data_i,
    input  logic        fifo_data_valid_i,
    output logic        fifo_data_ready_o,
    output logic        fifo_err_o,
    input  logic        cfg_en_i,
    input  logic        cfg_2ch_i,
    input  logic [4:0]  cfg_num_bits_i,
    input  logic [3:0]  cfg_num_word_i,
    input  logic        cfg_lsb_first_i,
    input  logic        cfg_tx_continuous_i,
    input  logic [8:0]  cfg_slave_dsp_offset_i
);

    tx_state_e  state_q, state_d;
    logic [8:0] off_cnt_q;
    logic [4:0] bit_cnt_q;
    logic [3:0] word_cnt_q;
    logic       err_q;

    logic bit_end, last_word, off_hit, flush;
    logic word_start, shift_en, stop_en;
    logic accept, fill0, fill1;
    logic full0, full1, ur0, ur1;

    assign flush     = ~cfg_en_i;
    assign bit_end   = (bit_cnt_q == cfg_num_bits_i);
    assign last_word = ~cfg_tx_continuous_i & (word_cnt_q == cfg_num_word_i);
    assign off_hit   = ((off_cnt_q + 9'd1) == cfg_slave_dsp_offset_i);

    // Ready depends only on registered slot flags, so a slot can never be
    // loaded and refilled on the same edge.
    assign fifo_data_ready_o = rstn_i & cfg_en_i & (state_q != ST_DONE) &
                               (~full0 | (cfg_2ch_i & ~full1));
    assign accept = fifo_data_valid_i & fifo_data_ready_o;
    assign fill0  = accept & ~full0;
    assign fill1  = accept & full0;
    assign fifo_err_o = err_q;

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!cfg_en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (i2s_ws_i)
                               state_d = (cfg_slave_dsp_offset_i == '0) ? ST_RUN : ST_OFFSET;
                ST_OFFSET: if (off_hit) state_d = ST_RUN;
                ST_RUN:    if (bit_end && last_word) state_d = ST_DONE;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        word_start = 1'b0;
        shift_en   = 1'b0;
        stop_en    = 1'b0;
        if (cfg_en_i) begin
            case (state_q)
                ST_IDLE:   word_start = i2s_ws_i & (cfg_slave_dsp_offset_i == '0);
                ST_OFFSET: word_start = off_hit;
                ST_RUN: begin
                    shift_en   = ~bit_end;
                    word_start = bit_end & ~last_word;
                    stop_en    = bit_end & last_word;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            off_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            off_cnt_q <= (cfg_en_i && state_q == ST_OFFSET) ? off_cnt_q + 9'd1 : '0;
            if (flush || word_start)
                bit_cnt_q <= '0;
            else if (shift_en)
                bit_cnt_q <= bit_cnt_q + 5'd1;
            if (flush)
                word_cnt_q <= '0;
            else if (state_q == ST_RUN && bit_end)
                word_cnt_q <= word_cnt_q + 4'd1;
            err_q <= word_start & (ur0 | ur1);
        end
    end

    i2s_tx_serializer u_ser_ch0 (
        .sck_i           (sck_i),
        .rstn_i          (rstn_i),
        .flush           (flush),
        .fill            (fill0),
        .fill_data       (fifo_data_i),
        .load            (word_start),
        .shift           (shift_en),
        .stop            (stop_en),
        .cfg_num_bits_i  (cfg_num_bits_i),
        .cfg_lsb_first_i (cfg_lsb_first_i),
        .slot_full       (full0),
        .underrun        (ur0),
        .sd              (i2s_ch0_o)
    );

    i2s_tx_serializer u_ser_ch1 (
        .sck_i           (sck_i),
        .rstn_i          (rstn_i),
        .flush           (flush),
        .fill            (fill1),
        .fill_data       (fifo_data_i),
        .load            (word_start & cfg_2ch_i),
        .shift           (shift_en & cfg_2ch_i),
        .stop            (stop_en & cfg_2ch_i),
        .cfg_num_bits_i  (cfg_num_bits_i),
        .cfg_lsb_first_i (cfg_lsb_first_i),
        .slot_full       (full1),
        .underrun        (ur1),
        .sd              (i2s_ch1_o)
    );

endmodule

// File: tb/tb_i2s_tx_dsp_channel.sv
// Bench for i2s_tx_dsp_channel: frame-timeline model checked every cycle plus literal expectations.
module tb_i2s_tx_dsp_channel;

    logic        sck = 1'b0;
    logic        rstn = 1'b0;
    logic        ws = 1'b0;
    logic        ch0, ch1, ready, err;
    logic [31:0] data = '0;
    logic        valid = 1'b0;
    logic        en = 1'b0, two = 1'b0, lsb = 1'b0, cont = 1'b0;
    logic [4:0]  nb = 5'd7;
    logic [3:0]  nw = 4'd0;
    logic [8:0]  off = 9'd0;

    int checks = 0;
    int errors = 0;

    always #5 sck = ~sck;

    i2s_tx_dsp_channel dut (
        .sck_i                  (sck),
        .rstn_i                 (rstn),
        .i2s_ws_i               (ws),
        .i2s_ch0_o              (ch0),
        .i2s_ch1_o              (ch1),
        .fifo_data_i            (data),
        .fifo_data_valid_i      (valid),
        .fifo_data_ready_o      (ready),
        .fifo_err_o             (err),
        .cfg_en_i               (en),
        .cfg_2ch_i              (two),
        .cfg_num_bits_i         (nb),
        .cfg_num_word_i         (nw),
        .cfg_lsb_first_i        (lsb),
        .cfg_tx_continuous_i    (cont),
        .cfg_slave_dsp_offset_i (off)
    );

    // Frame-timeline model: position since first bit gives word and bit index.
    int          cyc = 0;
    bit          m_active = 0, m_done = 0, m_hs = 0;
    int          m_start = 0, m_sync = 0;
    logic [31:0] m_slot [2];
    bit          m_full [2];
    logic [31:0] m_cur  [2];
    logic        e_ch   [2];
    logic        e_err, e_ready;
    logic        h_ch0 [8192];
    logic        h_ch1 [8192];
    logic        h_err [8192];
    logic [31:0] tx_q [$];

    function automatic logic model_ready();
        return rstn & en & !m_done & (!m_full[0] | (two & !m_full[1]));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge sck) begin
        int k, w, i, tgt, len;
        logic rdy_pre;
        logic [63:0] msk;
        cyc++;
        rdy_pre = model_ready();
        m_hs = 0;
        e_err = 0;
        e_ch[0] = 0;
        e_ch[1] = 0;
        if (!rstn || !en) begin
            m_active = 0;
            m_done = 0;
            for (int c = 0; c < 2; c++) begin
                m_full[c] = 0;
                m_slot[c] = '0;
                m_cur[c] = '0;
            end
        end else begin
            m_hs = valid & rdy_pre;
            tgt = m_full[0] ? 1 : 0;
            len = int'(nb) + 1;
            msk = (64'd1 << len) - 64'd1;
            if (!m_active && !m_done && ws) begin
                m_active = 1;
                m_sync = cyc;
                m_start = cyc + int'(off);
            end
            if (m_active && cyc >= m_start) begin
                k = cyc - m_start;
                w = k / len;
                i = k % len;
                if (!cont && w > int'(nw)) begin
                    m_done = 1;
                    m_active = 0;
                end else begin
                    for (int c = 0; c < 2; c++) begin
                        if (c == 0 || two) begin
                            if (i == 0) begin
                                if (m_full[c]) m_cur[c] = m_slot[c] & msk[31:0];
                                else begin
                                    m_cur[c] = '0;
                                    e_err = 1;
                                end
                                m_full[c] = 0;
                            end
                            e_ch[c] = m_cur[c][lsb ? i : (int'(nb) - i)];
                        end
                    end
                end
            end
            if (m_hs) begin
                m_slot[tgt] = data;
                m_full[tgt] = 1;
            end
        end
        #1;
        e_ready = model_ready();
        if (cyc < 8192) begin
            h_ch0[cyc] = ch0;
            h_ch1[cyc] = ch1;
            h_err[cyc] = err;
        end
        check("ch0", ch0, e_ch[0]);
        check("ch1", ch1, e_ch[1]);
        check("err", err, e_err);
        check("ready", ready, e_ready);
    end

    // FIFO side: present the queue head, pop it once the model saw a handshake.
    always @(negedge sck) begin
        if (m_hs && tx_q.size() > 0) void'(tx_q.pop_front());
        if (tx_q.size() > 0) begin
            valid = 1'b1;
            data = tx_q[0];
        end else begin
            valid = 1'b0;
            data = '0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge sck);
    endtask

    task automatic sync_pulse(output int s);
        ws = 1'b1;
        step(1);
        ws = 1'b0;
        s = m_sync;
    endtask

    task automatic disable_all();
        en = 1'b0;
        tx_q.delete();
        step(2);
    endtask

    initial begin
        int s;
        int any1;
        logic [15:0] pat16;
        logic [31:0] w32;
        logic [7:0]  pat8;

        // Reset values
        step(2);
        #1;
        check("rst_ch0", ch0, 0);
        check("rst_ch1", ch1, 0);
        check("rst_err", err, 0);
        check("rst_ready", ready, 0);
        @(negedge sck);
        rstn = 1'b1;

        // 8-bit MSB-first, one lane, continuous, offset 0, then reset mid-run
        nb = 5'd7; lsb = 0; two = 0; cont = 1; off = 9'd0; en = 1;
        tx_q.push_back(32'hA5); tx_q.push_back(32'h3C);
        tx_q.push_back(32'hFF); tx_q.push_back(32'hFF);
        step(4);
        sync_pulse(s);
        step(19);
        rstn = 1'b0;
        #1;
        check("rstrun_ch0", ch0, 0);
        check("rstrun_err", err, 0);
        check("rstrun_ready", ready, 0);
        tx_q.delete();
        step(2);
        #1;
        check("rsthold_ready", ready, 0);
        pat16 = 16'hA53C;
        for (int i = 0; i < 16; i++)
            check("msb8_bit", h_ch0[s + i], pat16[15 - i]);
        check("msb8_w2", h_ch0[s + 16], 1);
        rstn = 1'b1;
        step(2);
        disable_all();

        // 16-bit LSB-first, two lanes, offset 3, one word per lane
        nb = 5'd15; lsb = 1; two = 1; cont = 0; nw = 4'd0; off = 9'd3; en = 1;
        tx_q.push_back(32'h0001); tx_q.push_back(32'h8000);
        step(4);
        sync_pulse(s);
        step(25);
        check("off_ch0_pre", h_ch0[s + 2], 0);
        check("off_ch0_first", h_ch0[s + 3], 1);
        check("off_ch0_next", h_ch0[s + 4], 0);
        check("off_ch1_first", h_ch1[s + 3], 0);
        check("off_ch1_last", h_ch1[s + 18], 1);
        check("off_ch1_done", h_ch1[s + 19], 0);
        check("off_err", h_err[s + 3], 0);
        disable_all();

        // 32-bit non-continuous, two words then DONE; third word refused
        nb = 5'd31; lsb = 0; two = 0; cont = 0; nw = 4'd1; off = 9'd0; en = 1;
        tx_q.push_back(32'hDEADBEEF); tx_q.push_back(32'h12345678);
        step(4);
        sync_pulse(s);
        step(70);
        tx_q.push_back(32'hCAFEF00D);
        step(3);
        #1;
        check("done_ready", ready, 0);
        check("done_ch0", ch0, 0);
        w32 = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++)
            check("w32_a", h_ch0[s + i], w32[31 - i]);
        w32 = 32'h12345678;
        for (int i = 0; i < 4; i++)
            check("w32_b", h_ch0[s + 28 + 32 + i], w32[3 - i]);
        check("w32_stop", h_ch0[s + 64], 0);
        disable_all();

        // Underrun: two lanes, only lane 0 has data
        nb = 5'd7; lsb = 0; two = 1; cont = 0; nw = 4'd0; off = 9'd0; en = 1;
        tx_q.push_back(32'h81);
        step(4);
        sync_pulse(s);
        step(12);
        check("ur_err_pre", h_err[s - 1], 0);
        check("ur_err", h_err[s], 1);
        check("ur_err_post", h_err[s + 1], 0);
        check("ur_ch0_first", h_ch0[s], 1);
        check("ur_ch0_mid", h_ch0[s + 1], 0);
        check("ur_ch0_last", h_ch0[s + 7], 1);
        any1 = 0;
        for (int i = 0; i < 8; i++) if (h_ch1[s + i] === 1'b1) any1++;
        check("ur_ch1_zero", any1, 0);
        disable_all();

        // Enable dropped mid-word, then clean restart
        nb = 5'd7; lsb = 0; two = 0; cont = 1; off = 9'd0; en = 1;
        tx_q.push_back(32'hFF); tx_q.push_back(32'hFF);
        step(4);
        sync_pulse(s);
        step(2);
        en = 1'b0;
        tx_q.delete();
        step(1);
        #1;
        check("endrop_ch0", ch0, 0);
        check("endrop_ready", ready, 0);
        check("endrop_before", h_ch0[s + 2], 1);
        en = 1'b1;
        tx_q.push_back(32'h5A);
        step(4);
        sync_pulse(s);
        step(10);
        pat8 = 8'h5A;
        for (int i = 0; i < 8; i++)
            check("restart_bit", h_ch0[s + i], pat8[7 - i]);
        check("restart_err", h_err[s], 0);
        check("restart_underrun", h_err[s + 8], 1);
        disable_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
